// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and the MEM stage.
// It raises one-cycle ready/error pulses and a combinational pipeline stall.
module mem_port_arbiter #(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 12,
  parameter int TimeoutCycles = 16,
  parameter int DataBurstMax  = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 InstRead,
  input  logic [31:0]          InstAddr,
  output logic [DataWidth-1:0] Instruction,
  output logic                 InstReady,
  input  logic                 DataRead,
  input  logic                 DataWrite,
  input  logic [31:0]          DataAddr,
  input  logic [DataWidth-1:0] DataWrData,
  output logic [DataWidth-1:0] DataRdData,
  output logic                 DataReady,
  output logic                 AlignErr,
  output logic                 BusErr,
  output logic                 PipeStall,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemWrData,
  input  logic [DataWidth-1:0] MemRdData,
  input  logic                 MemAck
);

  localparam int TW = $clog2(TimeoutCycles);
  localparam int BW = $clog2(DataBurstMax + 1);
  localparam logic [TW-1:0] TLast = TW'(TimeoutCycles - 1);
  localparam logic [BW-1:0] BMax  = BW'(DataBurstMax);
  localparam logic [DataWidth-1:0] Poison =
    DataWidth'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic            gnt_data;
  logic            gnt_wr;
  logic [TW-1:0]   tcnt;
  logic [BW-1:0]   bcnt;

  logic            data_req;
  logic            pick_data;
  logic            pick_inst;
  logic            sel_wr;
  logic [31:0]     sel_addr;
  logic [DataWidth-1:0] rsp_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{InstAddr[31:AddrWidth+2],
                              DataAddr[31:AddrWidth+2]};

  always_comb begin
    data_req  = DataRead | DataWrite;
    // The data port wins unless it has starved a waiting fetch.
    pick_data = data_req & ~((bcnt == BMax) & InstRead);
    pick_inst = ~pick_data & InstRead;
    sel_wr    = pick_data & DataWrite;
    sel_addr  = pick_data ? DataAddr : InstAddr;
    rsp_data  = MemAck ? MemRdData : Poison;
  end

  assign PipeStall = (InstRead & ~InstReady) |
                     (data_req & ~DataReady);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state       <= IDLE;
      gnt_data    <= 1'b0;
      gnt_wr      <= 1'b0;
      tcnt        <= '0;
      bcnt        <= '0;
      Instruction <= '0;
      DataRdData  <= '0;
      InstReady   <= 1'b0;
      DataReady   <= 1'b0;
      AlignErr    <= 1'b0;
      BusErr      <= 1'b0;
      MemReq      <= 1'b0;
      MemWe       <= 1'b0;
      MemAddr     <= '0;
      MemWrData   <= '0;
    end else begin
      InstReady <= 1'b0;
      DataReady <= 1'b0;
      AlignErr  <= 1'b0;
      BusErr    <= 1'b0;
      if (!InstRead) bcnt <= '0;
      unique case (state)
        IDLE: begin
          if (pick_data | pick_inst) begin
            gnt_data <= pick_data;
            gnt_wr   <= sel_wr;
            if (pick_inst)
              bcnt <= '0;
            else if (InstRead && bcnt != BMax)
              bcnt <= bcnt + 1'b1;
            if (sel_addr[1:0] != 2'b00) begin
              state    <= RESP;
              AlignErr <= 1'b1;
              if (pick_data) begin
                DataReady <= 1'b1;
                if (!sel_wr) DataRdData <= '0;
              end else begin
                InstReady   <= 1'b1;
                Instruction <= '0;
              end
            end else begin
              state     <= ACCESS;
              MemReq    <= 1'b1;
              MemWe     <= sel_wr;
              MemAddr   <= sel_addr[AddrWidth+1:2];
              MemWrData <= sel_wr ? DataWrData : '0;
              tcnt      <= '0;
            end
          end
        end
        ACCESS: begin
          if (MemAck || tcnt == TLast) begin
            state  <= RESP;
            MemReq <= 1'b0;
            MemWe  <= 1'b0;
            BusErr <= ~MemAck;
            if (gnt_data) begin
              DataReady <= 1'b1;
              if (!gnt_wr) DataRdData <= rsp_data;
            end else begin
              InstReady   <= 1'b1;
              Instruction <= rsp_data;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks of mem_port_arbiter against a
// transaction-level model of grants, memory contents and timing.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TO = 16;
  localparam int BM = 2;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic InstRead = 1'b0, DataRead = 1'b0, DataWrite = 1'b0;
  logic [31:0] InstAddr = '0, DataAddr = '0;
  logic [DW-1:0] DataWrData = '0, MemRdData = '0;
  logic MemAck = 1'b0;
  logic [DW-1:0] Instruction, DataRdData, MemWrData;
  logic InstReady, DataReady, AlignErr, BusErr, PipeStall;
  logic MemReq, MemWe;
  logic [AW-1:0] MemAddr;

  always #5 Clk = ~Clk;

  mem_port_arbiter #(
    .DataWidth(DW), .AddrWidth(AW),
    .TimeoutCycles(TO), .DataBurstMax(BM)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .InstRead(InstRead), .InstAddr(InstAddr),
    .Instruction(Instruction), .InstReady(InstReady),
    .DataRead(DataRead), .DataWrite(DataWrite),
    .DataAddr(DataAddr), .DataWrData(DataWrData),
    .DataRdData(DataRdData), .DataReady(DataReady),
    .AlignErr(AlignErr), .BusErr(BusErr),
    .PipeStall(PipeStall),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData),
    .MemAck(MemAck)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // requester side
  bit ip, dp, dw, dboth, hold_i, hold_d, rnd;
  logic [31:0] ia, da;
  logic [DW-1:0] dd;

  // model side
  typedef enum {FREE, ACC, RESP1} ph_t;
  ph_t ph;
  int streak, acc_cnt, ack_wait, ackmode, spur;
  bit gport, gwr;
  logic [AW-1:0] gword;
  logic [DW-1:0] gwd, exp_inst, exp_drd;
  bit e_ir, e_dr, e_al, e_be, e_req;
  int glog[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rnd_addr(input bit mis_ok);
    logic [31:0] a;
    a = $urandom();
    a[13:8] = '0;
    a[1:0]  = 2'b00;
    if (mis_ok && $urandom_range(0, 7) == 0)
      a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic drive();
    InstRead   = ip;
    InstAddr   = ia;
    DataRead   = dp & (~dw | dboth);
    DataWrite  = dp & dw;
    DataAddr   = da;
    DataWrData = dd;
  endtask

  task automatic model_reset();
    ph = FREE; streak = 0;
    exp_inst = '0; exp_drd = '0;
    e_ir = 0; e_dr = 0; e_al = 0; e_be = 0; e_req = 0;
  endtask

  task automatic finish_acc(input logic [DW-1:0] v);
    if (gport) begin
      e_dr = 1;
      if (!gwr) exp_drd = v;
    end else begin
      e_ir = 1;
      exp_inst = v;
    end
    ph = RESP1;
  endtask

  // Advance the model over the edge that just happened.
  task automatic model_edge();
    bit pd;
    logic [31:0] a;
    e_ir = 0; e_dr = 0; e_al = 0; e_be = 0;
    if (!ip) streak = 0;
    case (ph)
      FREE: if (ip || dp) begin
        pd = dp && !(streak == BM && ip);
        gport = pd;
        gwr = pd && dw;
        glog.push_back(int'(pd));
        if (!pd) streak = 0;
        else if (ip && streak < BM) streak++;
        a = pd ? da : ia;
        gword = a[AW+1:2];
        gwd = dd;
        if (a[1:0] != 2'b00) begin
          e_al = 1;
          finish_acc('0);
        end else begin
          ph = ACC;
          acc_cnt = 0;
          ack_wait = (ackmode == -1) ? $urandom_range(0, 3) :
                     (ackmode == -2) ? 1000 : ackmode;
        end
      end
      ACC: if (MemAck) begin
        if (gwr) mem[gword] = gwd;
        finish_acc(mem[gword]);
      end else begin
        acc_cnt++;
        if (acc_cnt == TO) begin
          e_be = 1;
          finish_acc(32'hDEADBEEF);
        end
      end
      RESP1: ph = FREE;
      default: ph = FREE;
    endcase
    e_req = (ph == ACC);
  endtask

  task automatic check_outs();
    chk("InstReady", 64'(InstReady), 64'(e_ir));
    chk("DataReady", 64'(DataReady), 64'(e_dr));
    chk("AlignErr", 64'(AlignErr), 64'(e_al));
    chk("BusErr", 64'(BusErr), 64'(e_be));
    chk("MemReq", 64'(MemReq), 64'(e_req));
    if (e_req) begin
      chk("MemWe", 64'(MemWe), 64'(gwr));
      chk("MemAddr", 64'(MemAddr), 64'(gword));
      if (gwr) chk("MemWrData", 64'(MemWrData), 64'(gwd));
    end
    chk("Instruction", 64'(Instruction), 64'(exp_inst));
    chk("DataRdData", 64'(DataRdData), 64'(exp_drd));
    chk("PipeStall", 64'(PipeStall),
        64'((ip & ~e_ir) | (dp & ~e_dr)));
  endtask

  task automatic update();
    if (e_ir) ip = hold_i;
    if (e_dr) dp = hold_d;
    if (rnd) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = rnd_addr(1);
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; dw = 1'($urandom_range(0, 1));
        dboth = 1'($urandom_range(0, 1));
        da = rnd_addr(1); dd = $urandom();
      end
    end
    drive();
    if (ph == ACC) begin
      if (ack_wait == 0) MemAck = 1'b1;
      else begin MemAck = 1'b0; ack_wait--; end
    end else if (spur == 2) MemAck = 1'b1;
    else MemAck = (spur == 1) && ($urandom_range(0, 3) == 0);
    MemRdData = MemAck ? mem[gword] : DW'($urandom());
  endtask

  task automatic cycle();
    @(posedge Clk); #1;
    model_edge();
    check_outs();
    update();
  endtask

  task automatic wait_rdy(input string tag, input bit port,
                          input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      cycle();
      if (port ? e_dr : e_ir) break;
    end
    chk(tag, 64'(i < bound), 64'(1));
  endtask

  task automatic drain();
    hold_i = 0; hold_d = 0; rnd = 0;
    for (int i = 0; i < 60 && (ip || dp || ph != FREE); i++)
      cycle();
    cycle();
  endtask

  logic [DW-1:0] saved;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom());
    ip = 0; dp = 0; dw = 0; dboth = 0; ia = '0; da = '0; dd = '0;
    hold_i = 0; hold_d = 0; rnd = 0; ackmode = -1; spur = 0;
    model_reset();
    drive();

    // reset values
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_Instruction", 64'(Instruction), 64'(0));
    chk("rst_DataRdData", 64'(DataRdData), 64'(0));
    chk("rst_readys", 64'({InstReady, DataReady}), 64'(0));
    chk("rst_errs", 64'({AlignErr, BusErr}), 64'(0));
    chk("rst_MemReq", 64'({MemReq, MemWe}), 64'(0));
    chk("rst_MemAddr", 64'(MemAddr), 64'(0));
    chk("rst_MemWrData", 64'(MemWrData), 64'(0));
    chk("rst_PipeStall", 64'(PipeStall), 64'(0));
    Rst = 1'b1;

    // fetch only, zero-wait memory
    mem[12'h010] = 32'h8C010004;
    ackmode = 0;
    ip = 1; ia = 32'h40; drive();
    wait_rdy("fetch_wait", 0, 10);
    chk("fetch_word", 64'(Instruction), 64'h8C010004);
    drain();

    // simultaneous fetch and store: data first
    glog.delete();
    saved = exp_drd;
    ip = 1; ia = 32'h44;
    dp = 1; dw = 1; dboth = 1; da = 32'h100; dd = 32'h1234;
    drive();
    wait_rdy("store_wait", 1, 10);
    wait_rdy("fetch2_wait", 0, 10);
    chk("order_store", 64'(glog.size() == 2 && glog[0] == 1
        && glog[1] == 0), 64'(1));
    chk("store_mem", 64'(mem[12'h040]), 64'h1234);
    chk("drd_hold", 64'(DataRdData), 64'(saved));
    drain();

    // load burst against a pending fetch
    glog.delete();
    ackmode = -1;
    hold_i = 1; hold_d = 1;
    ip = 1; ia = 32'h80;
    dp = 1; dw = 0; dboth = 0; da = 32'h204; drive();
    for (int i = 0; i < 80 && glog.size() < 6; i++) cycle();
    chk("burst_order", 64'(glog.size() >= 6 && glog[0] == 1 &&
        glog[1] == 1 && glog[2] == 0 && glog[3] == 1 &&
        glog[4] == 1 && glog[5] == 0), 64'(1));
    drain();

    // misaligned load
    dp = 1; dw = 0; da = 32'h102; drive();
    wait_rdy("mis_wait", 1, 10);
    chk("mis_align", 64'(AlignErr), 64'(1));
    chk("mis_data", 64'(DataRdData), 64'(0));
    drain();

    // hung memory, then late acks
    ackmode = -2;
    dp = 1; dw = 0; da = 32'h208; drive();
    wait_rdy("to_wait", 1, TO + 6);
    chk("to_buserr", 64'(BusErr), 64'(1));
    chk("to_data", 64'(DataRdData), 64'hDEADBEEF);
    hold_d = 0; spur = 2;
    repeat (5) cycle();
    spur = 0; ackmode = -1;
    drain();

    // reset in the middle of an access
    ackmode = -2;
    ip = 1; ia = 32'h48; drive();
    repeat (3) cycle();
    chk("pre_rst_req", 64'(MemReq), 64'(1));
    #2 Rst = 1'b0;
    #1;
    chk("mid_rst_req", 64'({MemReq, MemWe}), 64'(0));
    chk("mid_rst_outs", 64'({InstReady, DataReady,
        AlignErr, BusErr}), 64'(0));
    chk("mid_rst_regs", 64'(Instruction | DataRdData), 64'(0));
    model_reset();
    ackmode = 0; MemAck = 1'b0;
    @(negedge Clk) Rst = 1'b1;
    wait_rdy("post_rst_fetch", 0, 10);
    chk("post_rst_word", 64'(Instruction), 64'(mem[12'h012]));
    drain();

    // random traffic
    ackmode = -1; spur = 1; rnd = 1;
    repeat (500) cycle();
    spur = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates the processor's instruction-fetch port and data (MEM-stage) port onto one shared single-port word memory with a req/ack handshake. It sits between the pipelined processor and the unified memory. It generates per-port ready pulses and a pipeline stall, so the processor can run from one memory. It also flags misaligned accesses and hung memory transactions.

Parameters:
DataWidth, 32, data/instruction width
AddrWidth, 12, memory word-address width
TimeoutCycles, 16, max cycles MemReq may wait for MemAck before abort
DataBurstMax, 2, consecutive data grants allowed while a fetch is pending

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
InstRead  in  1  fetch request, level, held until InstReady
InstAddr  in  32  fetch byte address
Instruction  out  DataWidth  fetched word, registered
InstReady  out  1  one-cycle pulse: Instruction valid
DataRead  in  1  load request, level
DataWrite  in  1  store request, level
DataAddr  in  32  load/store byte address
DataWrData  in  DataWidth  store data
DataRdData  out  DataWidth  load result, registered
DataReady  out  1  one-cycle pulse: data access complete
AlignErr  out  1  one-cycle pulse with Ready: access rejected, misaligned
BusErr  out  1  one-cycle pulse with Ready: access aborted by timeout
PipeStall  out  1  combinational: some request pending and not yet ready
MemReq  out  1  memory request, registered
MemWe  out  1  write enable, valid with MemReq
MemAddr  out  AddrWidth  word address = byte address[AddrWidth+1:2]
MemWrData  out  DataWidth  store data, valid with MemReq
MemRdData  in  DataWidth  read data, valid when MemAck=1
MemAck  in  1  memory completion, sampled at rising edge

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE. All registered outputs 0: Instruction, DataRdData, InstReady, DataReady, AlignErr, BusErr, MemReq, MemWe, MemAddr, MemWrData. Timeout counter and burst counter 0. Reset mid-transaction drops MemReq immediately and abandons the access. A later MemAck is ignored.
- States: IDLE, ACCESS, RESP.
- IDLE: requests are sampled at the edge. The grant goes to the data port if DataRead|DataWrite, unless burst count = DataBurstMax and InstRead=1, in which case the fetch wins. Otherwise the fetch is granted if InstRead. No request: stay in IDLE.
- Burst counter: +1 per data grant while InstRead=1 (saturates at DataBurstMax). Cleared on any fetch grant or when InstRead=0.
- DataRead and DataWrite both high: treated as a write.
- Grant with addr[1:0]!=0: no memory request. Go to RESP with the granted port's Ready=1 and AlignErr=1. Read data register is set to 0.
- Aligned grant: go to ACCESS with MemReq=1. MemWe=1 for a write. MemAddr and MemWrData are latched from the granted port and held stable while in ACCESS. The timeout counter is cleared.
- ACCESS, MemAck=1 at edge: on a read, MemRdData is captured into Instruction or DataRdData. MemReq and MemWe drop. Go to RESP with the granted Ready=1.
- ACCESS, MemAck=0: counter +1. When the counter reaches TimeoutCycles-1 with no ack, MemReq drops and the FSM goes to RESP with Ready=1 and BusErr=1. The read register is set to 32'hDEADBEEF.
- RESP: lasts exactly one cycle, then IDLE. Requests are not sampled in RESP.
- Ready/err pulses are exactly one cycle wide.
- Minimum latency (zero-wait memory): request sampled at edge k, MemReq high after k, ack at k+1, Ready high after k+1. Next grant is sampled at k+3. Throughput is one access per 3 cycles.
- A requester holding its request through RESP is re-served from IDLE. Requesters drop or update the request in the Ready cycle.
- Writes leave DataRdData unchanged. Instruction and DataRdData hold their value until the next completion of their own port.
- MemAck while in IDLE or RESP is ignored.
- PipeStall = (InstRead & ~InstReady) | ((DataRead|DataWrite) & ~DataReady).

Test Plan:
- Fetch only: InstRead=1, InstAddr=0x40, ack 1 cycle after MemReq, MemRdData=0x8C010004 -> MemAddr=0x010, MemWe=0, InstReady pulses 1 cycle with Instruction=0x8C010004. PipeStall=1 until the pulse.
- Simultaneous fetch and store to 0x100 with data 0x1234 -> data granted first: MemWe=1, MemAddr=0x040, MemWrData=0x1234, DataReady pulses. Fetch served next; DataRdData unchanged.
- Continuous loads plus pending fetch -> grant order data, data, inst, data, data, inst with DataBurstMax=2.
- Load at 0x102 -> MemReq never asserts; DataReady=1 and AlignErr=1 for one cycle; DataRdData=0.
- Load with MemAck held 0 -> MemReq drops after 16 cycles; DataReady=1, BusErr=1, DataRdData=0xDEADBEEF. A late MemAck is ignored.
- Rst low mid-ACCESS -> MemReq=0 immediately, all outputs 0. After release, a pending fetch is granted normally.
